ppu_frame_writer: RTL

//  Bus master that feeds PPU table writes (attr/color/pattern/sprite) on the PPU slave port (chipselect/write/address/writedata).

---
 rtl/ppu_pkg.sv | 25 ++
 rtl/cmd_fifo.sv | 68 ++++++
 rtl/ppu_frame_writer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ppu_pkg.sv
// Shared types for the PPU table writer: table base addresses, writer FSM states
// and the command word carried through the frame FIFO.
package ppu_pkg;

  localparam int CMD_ADDR_W = 16;
  localparam int CMD_DATA_W = 32;

  localparam logic [CMD_ADDR_W-1:0] ATTR_BASE    = 16'h0000;
  localparam logic [CMD_ADDR_W-1:0] COLOR_BASE   = 16'h1000;
  localparam logic [CMD_ADDR_W-1:0] PATTERN_BASE = 16'h2000;
  localparam logic [CMD_ADDR_W-1:0] SPRITE_BASE  = 16'h3000;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } writer_state_t;

  typedef struct packed {
    logic                  last;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// First-word-fall-through command FIFO; tag_last marks the newest stored entry
// as a batch boundary so a full FIFO without a boundary can still drain.
module cmd_fifo
  import ppu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     rdata,
  input  logic                     tag_last,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign tail_ptr = wr_ptr - AW'(1);

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
    if (tag_last) begin
      mem[tail_ptr].last <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ppu_frame_writer.sv
// Buffers PPU table writes in frame batches and drains exactly one complete
// batch per vertical blank so sprite/attribute tables never change mid-scanout.
module ppu_frame_writer
  import ppu_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int VACTIVE = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  input  logic [9:0]        vcount,
  input  logic              waitrequest,
  output logic              chipselect,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic [15:0]       frames_done,
  output logic              late_err,
  output logic              force_err,
  output writer_state_t     state
);

  localparam int CW = $clog2(DEPTH) + 1;

  cmd_t          push_cmd;
  cmd_t          head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] pending;
  logic          push;
  logic          pop;
  logic          tag_last;
  logic          pend_inc;
  logic          pend_dec;
  logic          vblank;
  logic          vblank_q;
  logic          vb_rise;
  logic          accept;
  logic          out_last;

  // Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready;
  // a bus write completes on an edge where chipselect && !waitrequest, and the
  // bus outputs are held unchanged until then.
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign push_cmd  = '{last: cmd_last, addr: cmd_addr, data: cmd_data};
  assign accept    = chipselect && !waitrequest;

  assign vblank  = (vcount >= 10'(VACTIVE));
  assign vb_rise = vblank && !vblank_q;

  // A full FIFO without any boundary would never drain; close the batch here.
  assign tag_last = (fifo_count == CW'(DEPTH)) && (pending == '0);

  // Load the next entry whenever the output stage is empty or just accepted,
  // except once the batch's last write is sitting on the bus.
  assign pop = (state == DRAIN) && (!chipselect || !waitrequest)
               && !(chipselect && out_last) && !fifo_empty;

  assign pend_inc = (push && cmd_last) || tag_last;
  assign pend_dec = pop && head.last;

  cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_cmd_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wdata    (push_cmd),
    .pop      (pop),
    .rdata    (head),
    .tag_last (tag_last),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if (pend_inc && !pend_dec) begin
      pending <= pending + CW'(1);
    end else if (!pend_inc && pend_dec) begin
      pending <= pending - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT;
      vblank_q    <= 1'b0;
      chipselect  <= 1'b0;
      address     <= '0;
      writedata   <= '0;
      out_last    <= 1'b0;
      frames_done <= '0;
      late_err    <= 1'b0;
      force_err   <= 1'b0;
    end else begin
      vblank_q <= vblank;
      if (tag_last) begin
        force_err <= 1'b1;
      end
      case (state)
        WAIT: begin
          if (vb_rise && (pending != '0)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The batch always completes; running past blanking is only flagged.
          if (!vblank) begin
            late_err <= 1'b1;
          end
          if (accept && out_last) begin
            chipselect  <= 1'b0;
            out_last    <= 1'b0;
            frames_done <= frames_done + 16'd1;
            state       <= HOLD;
          end else if (pop) begin
            chipselect <= 1'b1;
            address    <= head.addr;
            writedata  <= head.data;
            out_last   <= head.last;
          end else if (accept) begin
            chipselect <= 1'b0;
          end
        end
        HOLD: begin
          if (!vblank) begin
            state <= WAIT;
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  assign write = chipselect;
  assign busy  = (state == DRAIN);

endmodule
